// File: rtl/axi_port_monitor_if.sv
// Per-port AXI handshake bundle observed by axi_port_monitor.
// Bit i (or slice i for lengths) belongs to master port i.
interface axi_port_monitor_if #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_WIDTH = 8
);
  logic [NUM_PORTS-1:0]           awvalid, awready;
  logic [NUM_PORTS-1:0]           arvalid, arready;
  logic [NUM_PORTS-1:0]           wvalid, wready, wlast;
  logic [NUM_PORTS-1:0]           bvalid, bready;
  logic [NUM_PORTS-1:0]           rvalid, rready, rlast;
  logic [NUM_PORTS*LEN_WIDTH-1:0] awlen, arlen;

  modport master (
    output awvalid, awready, arvalid, arready, wvalid, wready, wlast,
           bvalid, bready, rvalid, rready, rlast, awlen, arlen
  );

  modport slave (
    input  awvalid, awready, arvalid, arready, wvalid, wready, wlast,
           bvalid, bready, rvalid, rready, rlast, awlen, arlen
  );
endinterface

// File: rtl/axi_port_monitor.sv
// Passive AXI protocol checker: per-port burst tracking, sticky error flags and event counter.
// Define AXI_PORT_MONITOR_MSG_EN to get a simulation $error on every flag rising edge.
module axi_port_monitor #(
  parameter int NUM_PORTS      = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  axi_port_monitor_if.slave      bus,
  input  logic                   clear_i,
  output logic [NUM_PORTS*4-1:0] err_o,
  output logic                   err_any_o,
  output logic [15:0]            err_count_o
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;
  localparam int         STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_PORTS*4-1:0] new_flags;
  logic [NUM_PORTS*4-1:0] err_q, flags_next;
  logic [15:0]            err_count_q, count_next;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic                 aw_hs, ar_hs, w_hs, b_hs, r_hs, any_hs;
    logic [LEN_WIDTH-1:0] awlen_p, arlen_p;
    logic [1:0]           w_state;
    logic                 r_state;
    logic [LEN_WIDTH-1:0] w_cnt, r_cnt;
    logic [STALL_W-1:0]   stall;
    logic                 aw_pend, ar_pend, w_pend;
    logic                 hs_viol, wlast_viol, rlast_viol, timeout_hit, busy;

    assign aw_hs  = bus.awvalid[p] & bus.awready[p];
    assign ar_hs  = bus.arvalid[p] & bus.arready[p];
    assign w_hs   = bus.wvalid[p]  & bus.wready[p];
    assign b_hs   = bus.bvalid[p]  & bus.bready[p];
    assign r_hs   = bus.rvalid[p]  & bus.rready[p];
    assign any_hs = aw_hs | ar_hs | w_hs | b_hs | r_hs;
    assign busy   = (w_state != W_IDLE) | (r_state != R_IDLE);

    assign awlen_p = bus.awlen[p*LEN_WIDTH +: LEN_WIDTH];
    assign arlen_p = bus.arlen[p*LEN_WIDTH +: LEN_WIDTH];

    // *_pend remembers "valid was up last cycle and was not accepted".
    assign hs_viol = (aw_pend & ~bus.awvalid[p])
                   | (ar_pend & ~bus.arvalid[p])
                   | (w_pend  & ~bus.wvalid[p])
                   | (aw_hs & (w_state != W_IDLE))
                   | (ar_hs & (r_state != R_IDLE))
                   | (w_hs  & (w_state == W_IDLE));

    assign wlast_viol  = w_hs & (w_state == W_DATA) & (bus.wlast[p] != (w_cnt == '0));
    assign rlast_viol  = r_hs & (r_state == R_DATA) & (bus.rlast[p] != (r_cnt == '0));
    assign timeout_hit = ~any_hs & busy & (stall == STALL_W'(TIMEOUT_CYCLES - 1));

    assign new_flags[p*4 +: 4] = {timeout_hit, rlast_viol, wlast_viol, hs_viol};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        w_state <= W_IDLE;
        r_state <= R_IDLE;
        w_cnt   <= '0;
        r_cnt   <= '0;
        stall   <= '0;
        aw_pend <= 1'b0;
        ar_pend <= 1'b0;
        w_pend  <= 1'b0;
      end else begin
        aw_pend <= bus.awvalid[p] & ~bus.awready[p];
        ar_pend <= bus.arvalid[p] & ~bus.arready[p];
        w_pend  <= bus.wvalid[p]  & ~bus.wready[p];

        case (w_state)
          W_IDLE: if (aw_hs) begin
            w_state <= W_DATA;
            w_cnt   <= awlen_p;
          end
          W_DATA: if (w_hs) begin
            if (w_cnt == '0) w_state <= W_RESP;
            else             w_cnt   <= w_cnt - 1'b1;
          end
          W_RESP: if (b_hs) w_state <= W_IDLE;
          default: w_state <= W_IDLE;
        endcase

        if (r_state == R_IDLE) begin
          if (ar_hs) begin
            r_state <= R_DATA;
            r_cnt   <= arlen_p;
          end
        end else if (r_hs) begin
          if (r_cnt == '0) r_state <= R_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end

        // Saturates so a long stall cannot wrap and re-arm the timeout.
        if (any_hs || !busy)                          stall <= '0;
        else if (stall != STALL_W'(TIMEOUT_CYCLES))   stall <= stall + 1'b1;
      end
    end
  end

  // A flag raised in the same cycle as clear_i survives the clear.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    flags_next = err_q | new_flags;
    count_next = err_count_q;
    if (clear_i) begin
      flags_next = new_flags;
      count_next = (|new_flags) ? 16'd1 : 16'd0;
    end else if ((|(new_flags & ~err_q)) && (err_count_q != 16'hFFFF)) begin
      count_next = err_count_q + 16'd1;
    end
  end

  // NOTE: only control/status registers exist here; all of them take the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= '0;
      err_count_q <= '0;
    end else begin
      err_q       <= flags_next;
      err_count_q <= count_next;
    end
  end

  assign err_o       = err_q;
  assign err_any_o   = |err_q;
  assign err_count_o = err_count_q;

`ifdef AXI_PORT_MONITOR_MSG_EN
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS*4; i++) begin
        if (flags_next[i] && !err_q[i])
          $error("axi_port_monitor: port %0d flag bit %0d raised", i / 4, i % 4);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_port_monitor.sv
// Directed bench for axi_port_monitor: burst-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_axi_port_monitor;
  localparam int NP      = 4;
  localparam int LW      = 8;
  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_i;
  logic [15:0] err_o;
  logic        err_any_o;
  logic [15:0] err_count_o;

  int n_vec  = 0;
  int n_fail = 0;

  axi_port_monitor_if #(.NUM_PORTS(NP), .LEN_WIDTH(LW)) bus ();

  axi_port_monitor #(.NUM_PORTS(NP), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .clear_i    (clear_i),
    .err_o      (err_o),
    .err_any_o  (err_any_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: bursts tracked as beats still owed ----------------
  int          w_left [NP];   // write beats still expected, 0 = no data phase open
  bit          w_wait_b [NP]; // all beats seen, response outstanding
  int          r_left [NP];
  int          stall [NP];
  bit          aw_stuck [NP], ar_stuck [NP], w_stuck [NP];
  logic [15:0] m_err;
  int          m_cnt;

  always @(posedge clk or posedge reset) begin
    logic [15:0] nf;
    logic [3:0]  f;
    bit          aw, ar, w, b, r, wr_busy, rd_busy;
    int          old_wl, old_rl;
    bit          old_wb;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        w_left[p] = 0; w_wait_b[p] = 0; r_left[p] = 0; stall[p] = 0;
        aw_stuck[p] = 0; ar_stuck[p] = 0; w_stuck[p] = 0;
      end
      m_err = '0;
      m_cnt = 0;
    end else begin
      nf = '0;
      for (int p = 0; p < NP; p++) begin
        aw = bus.awvalid[p] & bus.awready[p];
        ar = bus.arvalid[p] & bus.arready[p];
        w  = bus.wvalid[p]  & bus.wready[p];
        b  = bus.bvalid[p]  & bus.bready[p];
        r  = bus.rvalid[p]  & bus.rready[p];
        old_wl = w_left[p]; old_wb = w_wait_b[p]; old_rl = r_left[p];
        wr_busy = (old_wl > 0) || old_wb;
        rd_busy = old_rl > 0;
        f = '0;
        if (aw_stuck[p] && !bus.awvalid[p]) f[0] = 1'b1;
        if (ar_stuck[p] && !bus.arvalid[p]) f[0] = 1'b1;
        if (w_stuck[p]  && !bus.wvalid[p])  f[0] = 1'b1;
        if (aw) begin
          if (wr_busy) f[0] = 1'b1;
          else         w_left[p] = int'(bus.awlen[p*LW +: LW]) + 1;
        end
        if (w) begin
          if (old_wl > 0) begin
            if (bus.wlast[p] != (old_wl == 1)) f[1] = 1'b1;
            w_left[p] = old_wl - 1;
            if (old_wl == 1) w_wait_b[p] = 1'b1;
          end else if (!old_wb) begin
            f[0] = 1'b1;
          end
        end
        if (b && old_wb) w_wait_b[p] = 1'b0;
        if (ar) begin
          if (rd_busy) f[0] = 1'b1;
          else         r_left[p] = int'(bus.arlen[p*LW +: LW]) + 1;
        end
        if (r && old_rl > 0) begin
          if (bus.rlast[p] != (old_rl == 1)) f[2] = 1'b1;
          r_left[p] = old_rl - 1;
        end
        if (aw || ar || w || b || r || !(wr_busy || rd_busy)) stall[p] = 0;
        else if (stall[p] < TIMEOUT) begin
          stall[p]++;
          if (stall[p] == TIMEOUT) f[3] = 1'b1;
        end
        aw_stuck[p] = bus.awvalid[p] & ~bus.awready[p];
        ar_stuck[p] = bus.arvalid[p] & ~bus.arready[p];
        w_stuck[p]  = bus.wvalid[p]  & ~bus.wready[p];
        nf[p*4 +: 4] = f;
      end
      if (clear_i) begin
        m_cnt = (nf != '0) ? 1 : 0;
        m_err = nf;
      end else begin
        if (((nf & ~m_err) != '0) && m_cnt < 65535) m_cnt++;
        m_err = m_err | nf;
      end
    end
  end

  always @(negedge clk) begin
    check("err_o",       32'(err_o),       32'(m_err));
    check("err_any_o",   32'(err_any_o),   32'(m_err != '0));
    check("err_count_o", 32'(err_count_o), 32'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.awvalid = '0; bus.awready = '0; bus.arvalid = '0; bus.arready = '0;
    bus.wvalid  = '0; bus.wready  = '0; bus.wlast   = '0;
    bus.bvalid  = '0; bus.bready  = '0;
    bus.rvalid  = '0; bus.rready  = '0; bus.rlast   = '0;
    bus.awlen   = '0; bus.arlen   = '0;
    clear_i     = 1'b0;
  endtask

  task automatic aw_hs(input int p, input int len);
    bus.awvalid[p] = 1'b1; bus.awready[p] = 1'b1; bus.awlen[p*LW +: LW] = 8'(len);
    tick();
    bus.awvalid[p] = 1'b0; bus.awready[p] = 1'b0;
  endtask

  task automatic ar_hs(input int p, input int len);
    bus.arvalid[p] = 1'b1; bus.arready[p] = 1'b1; bus.arlen[p*LW +: LW] = 8'(len);
    tick();
    bus.arvalid[p] = 1'b0; bus.arready[p] = 1'b0;
  endtask

  task automatic w_beat(input int p, input bit last);
    bus.wvalid[p] = 1'b1; bus.wready[p] = 1'b1; bus.wlast[p] = last;
    tick();
    bus.wvalid[p] = 1'b0; bus.wready[p] = 1'b0; bus.wlast[p] = 1'b0;
  endtask

  task automatic r_beat(input int p, input bit last);
    bus.rvalid[p] = 1'b1; bus.rready[p] = 1'b1; bus.rlast[p] = last;
    tick();
    bus.rvalid[p] = 1'b0; bus.rready[p] = 1'b0; bus.rlast[p] = 1'b0;
  endtask

  task automatic b_hs(input int p);
    bus.bvalid[p] = 1'b1; bus.bready[p] = 1'b1;
    tick();
    bus.bvalid[p] = 1'b0; bus.bready[p] = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(2);
    check("reset_err",   32'(err_o),       32'h0);
    check("reset_count", 32'(err_count_o), 32'h0);
    reset = 1'b0;
    tick();

    // Clean 4-beat write on port 1
    aw_hs(1, 3);
    for (int i = 0; i < 4; i++) w_beat(1, i == 3);
    b_hs(1);
    tick();
    check("clean_burst_err",   32'(err_o),       32'h0);
    check("clean_burst_count", 32'(err_count_o), 32'h0);

    // Early wlast on port 0, then missing wlast on the true last beat
    aw_hs(0, 1);
    w_beat(0, 1'b1);
    check("early_wlast_err",   32'(err_o),       32'h0002);
    check("early_wlast_count", 32'(err_count_o), 32'd1);
    w_beat(0, 1'b0);
    b_hs(0);
    check("repeat_wlast_count", 32'(err_count_o), 32'd1);
    do_clear();
    check("clear_err",   32'(err_o),       32'h0);
    check("clear_count", 32'(err_count_o), 32'h0);

    // arvalid withdrawn on port 2
    bus.arvalid[2] = 1'b1;
    tick(2);
    bus.arvalid[2] = 1'b0;
    check("ar_drop_pending", 32'(err_o), 32'h0);
    tick();
    check("ar_drop_err",   32'(err_o),       32'h0100);
    check("ar_drop_count", 32'(err_count_o), 32'd1);
    do_clear();

    // W handshake while idle; then simultaneous violations racing clear_i
    w_beat(3, 1'b1);
    check("w_idle_err", 32'(err_o), 32'h1000);
    bus.wvalid[0] = 1'b1; bus.wready[0] = 1'b1;
    bus.wvalid[2] = 1'b1; bus.wready[2] = 1'b1;
    clear_i = 1'b1;
    tick();
    idle_inputs();
    check("set_vs_clear_err",   32'(err_o),       32'h0101);
    check("set_vs_clear_count", 32'(err_count_o), 32'd1);
    w_beat(1, 1'b0);
    check("second_event_err",   32'(err_o),       32'h0111);
    check("second_event_count", 32'(err_count_o), 32'd2);
    do_clear();

    // Read stall timeout on port 3
    ar_hs(3, 0);
    tick(TIMEOUT - 1);
    check("timeout_not_yet", 32'(err_o), 32'h0);
    tick();
    check("timeout_err",   32'(err_o),       32'h8000);
    check("timeout_count", 32'(err_count_o), 32'd1);
    tick(3);
    check("timeout_held_count", 32'(err_count_o), 32'd1);
    r_beat(3, 1'b1);
    check("timeout_close_err", 32'(err_o), 32'h8000);
    do_clear();

    // Missing rlast on port 0, then AW handshake outside W_IDLE on port 2
    ar_hs(0, 2);
    r_beat(0, 1'b0);
    r_beat(0, 1'b0);
    check("rlast_pending", 32'(err_o), 32'h0);
    r_beat(0, 1'b0);
    check("rlast_err", 32'(err_o), 32'h0004);
    aw_hs(2, 0);
    aw_hs(2, 0);
    check("aw_busy_err",   32'(err_o),       32'h0104);
    check("aw_busy_count", 32'(err_count_o), 32'd2);
    w_beat(2, 1'b1);
    b_hs(2);
    do_clear();

    // Reset in the middle of a port 1 burst, then a clean single-beat burst
    aw_hs(1, 3);
    w_beat(1, 1'b0);
    reset = 1'b1;
    tick(2);
    check("mid_reset_count", 32'(err_count_o), 32'h0);
    reset = 1'b0;
    tick();
    aw_hs(1, 0);
    w_beat(1, 1'b1);
    b_hs(1);
    tick();
    check("post_reset_err",   32'(err_o),       32'h0);
    check("post_reset_any",   32'(err_any_o),   32'h0);
    check("post_reset_count", 32'(err_count_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_port_monitor.md
AXI_PORT_MONITOR -- requirements
Module: axi_port_monitor

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of monitored AXI master ports.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of awlen/arlen per port.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, stall cycles before timeout flag.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports awvalid, awready, arvalid, arready, wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast  in  NUM_PORTS each  per-port handshake bits, bit i = port i.
REQ-007 SHALL have ports awlen, arlen  in  NUM_PORTS*LEN_WIDTH  burst length per port, slice i = port i.
REQ-008 SHALL have port clear_i  in  1  synchronous clear of flags and counter.
REQ-009 SHALL have port err_o  out  NUM_PORTS*4  sticky flags per port: [0] handshake violation, [1] wlast mismatch, [2] rlast mismatch, [3] timeout.
REQ-010 SHALL have port err_any_o  out  1  OR of all err_o bits.
REQ-011 SHALL have port err_count_o  out  16  saturating error-event counter.

Function
REQ-012 SHALL define handshake on a channel as valid & ready in the same rising clk edge.
REQ-013 SHALL run per port an independent write FSM: W_IDLE -> W_DATA on AW handshake (beat counter loaded with awlen); W_DATA -> W_RESP on W handshake with counter 0; W_RESP -> W_IDLE on B handshake.
REQ-014 SHALL decrement the write beat counter on each W handshake in W_DATA while counter is nonzero.
REQ-015 SHALL set bit [1] when a W handshake in W_DATA has wlast=1 with counter nonzero, or wlast=0 with counter 0; state transitions still follow the counter.
REQ-016 SHALL run per port a read FSM: R_IDLE -> R_DATA on AR handshake (counter loaded with arlen); R_DATA -> R_IDLE on R handshake with counter 0; rlast checked as REQ-015, setting bit [2].
REQ-017 SHALL set bit [0] when awvalid, arvalid or wvalid falls from 1 to 0 without a handshake in the prior cycle, when an AW handshake occurs outside W_IDLE, when an AR handshake occurs outside R_IDLE, or when a W handshake occurs in W_IDLE; the offending handshake is otherwise ignored.
REQ-018 SHALL keep per port a stall counter incremented each cycle either FSM is non-idle and no handshake occurs on any channel of that port, cleared on any handshake of that port or when both FSMs are idle.
REQ-019 SHALL set bit [3] when the stall counter reaches TIMEOUT_CYCLES; counter SHALL hold at TIMEOUT_CYCLES without wrapping.
REQ-020 SHALL register all flags; a violation at edge N is visible on err_o after edge N, i.e. one-cycle latency.
REQ-021 SHALL increment err_count_o by exactly 1 in any cycle where at least one err_o bit transitions 0->1, regardless of how many bits rise; saturate at 16'hFFFF.
REQ-022 SHALL on clear_i=1 zero err_o and err_count_o at the next edge; FSMs and beat/stall counters unaffected.
REQ-023 SHALL give a new flag set priority over clear_i in the same cycle: the bit ends set and err_count_o ends 1.
REQ-024 SHALL treat awlen/arlen of 0 as single-beat bursts (last expected on first beat).

Reset
REQ-025 SHALL on reset=1 asynchronously drive err_o, err_any_o, err_count_o to 0, all FSMs to IDLE, all counters to 0.
REQ-026 SHALL discard any in-flight burst state on reset mid-operation; no flag is raised for the abandoned burst.

Configuration
REQ-027 SHALL, with macro AXI_PORT_MONITOR_MSG_EN defined, issue a simulation $error naming port index and flag bit on every 0->1 flag transition.
REQ-028 SHALL, without AXI_PORT_MONITOR_MSG_EN, emit no messages; flag, counter and FSM behaviour identical.

Verification
REQ-029 Port 1: AW awlen=3, four W beats with wlast on 4th, B -> err_o all 0, err_count_o=0.
REQ-030 Port 0: AW awlen=1, wlast=1 on first beat -> err_o[1]=1 one cycle later, err_count_o=1.
REQ-031 Port 2: arvalid=1 for 2 cycles, dropped without arready -> err_o[8]=1, err_count_o=1.
REQ-032 Port 3: AR arlen=0, no rvalid for 256 cycles, TIMEOUT_CYCLES=256 -> err_o[15]=1 after edge 256, err_count_o=1.
REQ-033 Ports 0 and 2 violate in same cycle while clear_i=1 -> both bits set, err_count_o=1.
REQ-034 Reset asserted mid-burst on port 1 (counter=2), then clean awlen=0 burst -> all outputs 0, no flags.
